// File: rtl/rca_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rca_seq_ctrl_pkg
// Shared definitions for the sequential ripple-carry adder controller.
//   LW           : slice width handled per cycle by the shared RCA_16bit
//   SLICE_IDX_W  : width of the slice index register (supports up to 8 slices)
//   state_t      : controller state encoding
// -----------------------------------------------------------------------------
package rca_seq_ctrl_pkg;

    localparam int LW          = 16;
    localparam int SLICE_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// rca_seq_ctrl_if
// Bundles the two requester channels and the response channel of
// rca_seq_ctrl.
//   reqN_valid/ready     : operand handshake for requester N (N = 0, 1)
//   reqN_a/b             : WORDS*LW-bit operands
//   reqN_cin             : initial carry-in
//   reqN_sub             : subtract select (only with RCA_SEQ_SUB_EN defined)
//   rsp_valid/ready      : result handshake
//   rsp_id/sum/cout      : owning requester, result, final carry-out
// Modports: master = requesters/consumer side, slave = controller side.
// -----------------------------------------------------------------------------
interface rca_seq_ctrl_if #(
    parameter int WORDS = 4,
    parameter int LW    = rca_seq_ctrl_pkg::LW
);
    localparam int W = WORDS * LW;

    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req0_cin;
    logic         req1_cin;
`ifdef RCA_SEQ_SUB_EN
    logic         req0_sub;
    logic         req1_sub;
`endif
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

`ifdef RCA_SEQ_SUB_EN
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, req0_sub, req1_sub, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, req0_sub, req1_sub, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`else
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`endif

endinterface

// File: rtl/RCA_16bit.sv
// -----------------------------------------------------------------------------
// RCA_16bit
// Purely combinational 16-bit ripple-carry adder built from full-adder cells.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : 16-bit sum
//   cout : carry out of bit 15
// -----------------------------------------------------------------------------
module RCA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_fa
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[16];

endmodule

// File: rtl/rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rca_seq_ctrl
// Two-requester wide adder that time-shares one RCA_16bit, producing one
// LW-bit slice per cycle (LSB slice first). Round-robin arbitration in IDLE,
// WORDS cycles of CALC, then DONE holds the result until rsp_ready.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rca_seq_ctrl_if.slave (requester and response channels)
//   busy  : high whenever the controller is not in IDLE
// Optional feature macro: RCA_SEQ_SUB_EN adds reqN_sub; sub=1 latches ~b
// with an initial carry of 1 so the result is a-b (cin ignored).
// -----------------------------------------------------------------------------
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int LW    = rca_seq_ctrl_pkg::LW
) (
    input  logic           clk,
    input  logic           rst_n,
    rca_seq_ctrl_if.slave  bus,
    output logic           busy
);

    localparam int W = WORDS * LW;
    localparam logic [SLICE_IDX_W-1:0] LAST_K = SLICE_IDX_W'(WORDS - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [SLICE_IDX_W-1:0] k_reg;
    logic                   carry_reg;
    logic                   last_grant_reg;
    logic                   id_reg;
    logic                   cout_reg;
    logic [W-1:0]           a_reg;
    logic [W-1:0]           b_reg;
    logic [W-1:0]           sum_reg;

    logic                   grant_any;
    logic                   grant_id;
    logic                   accept;
    logic [W-1:0]           in_a;
    logic [W-1:0]           in_b;
    logic                   in_cin;
    logic [LW-1:0]          rca_sum;
    logic                   rca_cout;

    // Round-robin: on contention the requester not granted last wins;
    // a lone valid requester wins regardless of history.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_reg;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // rst_n gates ready so nothing is offered while reset is asserted.
    assign accept         = (state_reg == IDLE) && grant_any;
    assign bus.req0_ready = rst_n && accept && !grant_id;
    assign bus.req1_ready = rst_n && accept &&  grant_id;

    // Operand selection for the winning requester.
    always_comb begin
        in_a   = grant_id ? bus.req1_a   : bus.req0_a;
        in_b   = grant_id ? bus.req1_b   : bus.req0_b;
        in_cin = grant_id ? bus.req1_cin : bus.req0_cin;
`ifdef RCA_SEQ_SUB_EN
        // Two's-complement subtract: a + ~b + 1.
        if (grant_id ? bus.req1_sub : bus.req0_sub) begin
            in_b   = ~in_b;
            in_cin = 1'b1;
        end
`endif
    end

    RCA_16bit u_rca (
        .a    (a_reg[int'(k_reg)*LW +: LW]),
        .b    (b_reg[int'(k_reg)*LW +: LW]),
        .cin  (carry_reg),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)         state_next = CALC;
            CALC:    if (k_reg == LAST_K) state_next = DONE;
            DONE:    if (bus.rsp_ready)  state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, slice-by-slice accumulation of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg          <= '0;
            carry_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            cout_reg       <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            sum_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg          <= in_a;
                        b_reg          <= in_b;
                        carry_reg      <= in_cin;
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        k_reg          <= '0;
                    end
                end
                CALC: begin
                    sum_reg[int'(k_reg)*LW +: LW] <= rca_sum;
                    carry_reg                     <= rca_cout;
                    if (k_reg == LAST_K) begin
                        k_reg    <= '0;
                        cout_reg <= rca_cout;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_cout  = cout_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rca_seq_ctrl
// Scoreboard bench for rca_seq_ctrl: expected results are queued as requests
// are driven and compared when the response handshake happens. Also checks
// reset values, latency, round-robin order/period, DONE stall and reset abort.
// RCA_SEQ_SUB_EN, when defined, enables the subtract case.
// -----------------------------------------------------------------------------
module tb_rca_seq_ctrl;

    localparam int WORDS = 4;
    localparam int LW    = 16;
    localparam int W     = WORDS * LW;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    rca_seq_ctrl_if #(.WORDS(WORDS), .LW(LW)) bus ();

    rca_seq_ctrl #(.WORDS(WORDS), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit cin, input bit sub);
        logic [W:0]   t;
        logic [W-1:0] be;
        logic         c;
        exp_t         e;
        be     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
        e.id   = id;
        e.sum  = t[W-1:0];
        e.cout = t[W];
        return e;
    endfunction

    task automatic set_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit cin, input bit sub, input bit v);
        if (id == 1'b0) begin
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_cin   = cin;
`ifdef RCA_SEQ_SUB_EN
            bus.req0_sub   = sub;
`endif
            bus.req0_valid = v;
        end else begin
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_cin   = cin;
`ifdef RCA_SEQ_SUB_EN
            bus.req1_sub   = sub;
`endif
            bus.req1_valid = v;
        end
        if (sub && v) begin
        end
    endtask

    // Drive one request and hold valid until accepted (bounded).
    task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit cin, input bit sub, input bit push);
        bit fired = 1'b0;
        set_req(id, a, b, cin, sub, 1'b1);
        if (push) sb.push_back(model(id, a, b, cin, sub));
        for (int i = 0; i < 40 && !fired; i++) begin
            @(negedge clk);
            fired = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); #1;
        end
        chk("accept", fired, 1'b1);
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    // Wait for all queued results to drain and the controller to go idle.
    task automatic drain();
        @(posedge clk); #1;
        for (int i = 0; i < 80 && (sb.size() != 0 || busy); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    // Both requesters valid continuously, n transactions each.
    task automatic contend(input int n);
        logic [W-1:0] a[2][4];
        logic [W-1:0] b[2][4];
        bit           c[2][4];
        int           cnt[2];
        int           last_t = -1;
        int           n_acc  = 0;
        bit           f0, f1;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 2; r++) begin
                a[r][i] = {$urandom, $urandom};
                b[r][i] = {$urandom, $urandom};
                c[r][i] = 1'($urandom_range(0, 1));
            end
            sb.push_back(model(1'b0, a[0][i], b[0][i], c[0][i], 1'b0));
            sb.push_back(model(1'b1, a[1][i], b[1][i], c[1][i], 1'b0));
        end
        cnt[0] = 0;
        cnt[1] = 0;
        set_req(1'b0, a[0][0], b[0][0], c[0][0], 1'b0, 1'b1);
        set_req(1'b1, a[1][0], b[1][0], c[1][0], 1'b0, 1'b1);
        for (int t = 0; t < 20 * n + 20 && n_acc < 2 * n; t++) begin
            @(negedge clk);
            f0 = bus.req0_valid && bus.req0_ready;
            f1 = bus.req1_valid && bus.req1_ready;
            if (f0 || f1) begin
                chk("grant_order", f1, n_acc % 2);
                if (last_t >= 0) chk("grant_period", cyc - last_t, WORDS + 2);
                last_t = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if ((r == 0 && f0) || (r == 1 && f1)) begin
                    cnt[r]++;
                    if (cnt[r] < n) set_req(r[0], a[r][cnt[r]], b[r][cnt[r]], c[r][cnt[r]], 1'b0, 1'b1);
                    else if (r == 0) bus.req0_valid = 1'b0;
                    else bus.req1_valid = 1'b0;
                end
            end
        end
        chk("contend_accepts", n_acc, 2 * n);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Response monitor: latency check and scoreboard compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                acc_cyc = cyc + 1;
            if (bus.rsp_valid && !prev_valid)
                chk("latency", cyc - acc_cyc, WORDS);
            prev_valid = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", bus.rsp_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("rsp id=%0d sum=%h cout=%0d (exp id=%0d sum=%h cout=%0d)",
                             bus.rsp_id, bus.rsp_sum, bus.rsp_cout, e.id, e.sum, e.cout);
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_sum", bus.rsp_sum, e.sum);
                    chk("rsp_cout", bus.rsp_cout, e.cout);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [W-1:0] ra, rb;
        int           hits;

        rst_n          = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req0_cin   = 1'b0;
        bus.req1_cin   = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        bus.req0_sub   = 1'b0;
        bus.req1_sub   = 1'b0;
`endif
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;

        // Reset state, with both requesters valid to show ready is gated.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready0", bus.req0_ready, 1'b0);
        chk("reset_ready1", bus.req1_ready, 1'b0);
        chk("reset_sum", bus.rsp_sum, '0);
        chk("reset_cout", bus.rsp_cout, 1'b0);
        chk("reset_id", bus.rsp_id, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry out of the lowest slice into the next.
        send(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
        drain();

        // Carry ripples through every slice.
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        drain();

        // Round-robin under continuous contention: 0,1,0,1 every WORDS+2 cycles.
        contend(2);
        drain();

        // Stall in DONE for 5 cycles.
        bus.rsp_ready = 1'b0;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        e  = model(1'b0, ra, rb, 1'b1, 1'b0);
        send(1'b0, ra, rb, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("stall_wait", bus.rsp_valid, 1'b1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_sum", bus.rsp_sum, e.sum);
            chk("stall_cout", bus.rsp_cout, e.cout);
            chk("stall_ready0", bus.req0_ready, 1'b0);
            chk("stall_ready1", bus.req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        drain();

        // Reset during the second CALC cycle discards the transaction.
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_sum", bus.rsp_sum, '0);
        chk("abort_cout", bus.rsp_cout, 1'b0);
        chk("abort_ready0", bus.req0_ready, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        repeat (WORDS + 3) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        chk("abort_no_rsp", hits, 0);
        @(posedge clk); #1;

        // Last-grant restored by reset: requester 0 wins first contention.
        contend(1);
        drain();

        // Random additions alternating requesters.
        for (int i = 0; i < 6; i++) begin
            send(i[0], {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        drain();

`ifdef RCA_SEQ_SUB_EN
        // 5 - 7 wraps to -2 with no carry out.
        send(1'b0, 64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
        drain();
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of 16-bit slices per operand (2..8).
REQ-002 SHALL have parameter LW, default 16, slice width, fixed to RCA_16bit width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester operand valid.
REQ-006 SHALL have ports req0_ready / req1_ready  out  1  operands accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  WORDS*LW  operands.
REQ-008 SHALL have ports req0_cin / req1_cin  in  1  initial carry-in.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  out  1  requester index owning the result.
REQ-012 SHALL have port rsp_sum  out  WORDS*LW  result.
REQ-013 SHALL have port rsp_cout  out  1  final carry-out.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL share one RCA_16bit instance among both requesters, computing one LW slice per cycle, LSB slice first.
REQ-016 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-017 IDLE: reqN_ready high only for the arbitration winner; transfer occurs on edge with valid&&ready; operands, cin and id latched; slice index k=0; go CALC.
REQ-018 Arbitration SHALL be round-robin: with both valid, winner is the requester not granted last; single valid wins unconditionally.
REQ-019 CALC: each cycle, slice k of rsp_sum <= RCA(a[k], b[k], carry); carry <= RCA cout; k <= k+1; after slice WORDS-1 go DONE, rsp_cout <= final carry.
REQ-020 Latency SHALL be exactly WORDS cycles from accepting edge to first cycle with rsp_valid=1; minimum transaction period WORDS+2 cycles.
REQ-021 DONE: rsp_valid=1, rsp_sum/rsp_cout/rsp_id stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE.
REQ-022 reqN_ready SHALL be 0 in CALC and DONE; requests arriving then are held by requester, not dropped.
REQ-023 Arithmetic SHALL be modulo 2^(WORDS*LW); overflow only visible via rsp_cout.
REQ-024 rsp_sum bits SHALL not change outside CALC slice writes.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, k=0, carry=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, both ready=0 (winner logic enabled only after release).
REQ-026 Last-grant register SHALL reset to 1 so requester 0 wins first contention.
REQ-027 Reset mid-CALC or mid-DONE SHALL discard the transaction; no rsp_valid pulse follows.

Configuration
REQ-028 Macro RCA_SEQ_SUB_EN: when defined, ports req0_sub / req1_sub (in, 1) exist; sub=1 latches ~b and forces initial carry 1, giving a-b; cin ignored.
REQ-029 Without RCA_SEQ_SUB_EN: no sub ports, addition only, cin used as given.

Structure
REQ-030 Shared package SHALL hold LW, state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and slice-index width.
REQ-031 Sole sub-module SHALL be existing RCA_16bit; arbiter and FSM remain inline.

Verification
REQ-032 req0: a=64'h0000_0000_0000_FFFF, b=1, cin=0 -> rsp_sum=64'h0000_0000_0001_0000, cout=0, id=0, rsp_valid 4 cycles after accept.
REQ-033 req1: a=b=64'hFFFF_FFFF_FFFF_FFFF, cin=1 -> rsp_sum=64'hFFFF_FFFF_FFFF_FFFF, cout=1, id=1 (worst-case carry across all slices).
REQ-034 Both valid continuously, rsp_ready=1 -> grants 0,1,0,1; each period 6 cycles.
REQ-035 rsp_ready held 0 for 5 cycles in DONE -> result stable, both ready=0, no new accept until handshake.
REQ-036 rst_n low in CALC cycle 2 -> outputs zero immediately, no rsp_valid; next request completes correctly.
REQ-037 RCA_SEQ_SUB_EN defined, sub=1, a=5, b=7 -> rsp_sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
